// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: core widths, control bit positions, the MEM/WB
// payload layout and the state encoding of the two-entry skid store.
package pipe_pkg;

    localparam int XLEN          = 64;
    localparam int REG_IDX_W     = 5;
    localparam int MEMWB_CTRL_W  = 2;

    localparam int CTRL_REGWRITE = 0;
    localparam int CTRL_MEMTOREG = 1;

    typedef struct packed {
        logic [MEMWB_CTRL_W-1:0] ctrl;
        logic [XLEN-1:0]         data1;
        logic [XLEN-1:0]         data0;
        logic [REG_IDX_W-1:0]    rd;
    } memwb_payload_t;

    // bit0 = main entry valid, bit1 = skid entry valid
    typedef enum logic [1:0] {
        SKID_EMPTY = 2'b00,
        SKID_MAIN  = 2'b01,
        SKID_FULL  = 2'b11
    } skid_state_t;

endpackage

// File: rtl/pipe_skid_buf.sv
// Two-entry main+skid store. in_ready comes straight from the skid-valid flop,
// so there is no combinational path from out_ready to in_ready.
//
//   state      | meaning
//   SKID_EMPTY | nothing held, output idle
//   SKID_MAIN  | main entry holds a beat, skid free
//   SKID_FULL  | main and skid both hold beats, upstream stalled
module pipe_skid_buf
    import pipe_pkg::*;
#(
    parameter int PAYLOAD_W = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 flush,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [PAYLOAD_W-1:0] in_payload,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [PAYLOAD_W-1:0] out_payload
);

    skid_state_t          state_q;
    skid_state_t          state_d;
    logic [PAYLOAD_W-1:0] main_q;
    logic [PAYLOAD_W-1:0] skid_q;
    logic                 load_main_in;
    logic                 load_main_skid;
    logic                 load_skid;

    assign out_valid   = state_q[0];
    assign in_ready    = !state_q[1];
    assign out_payload = main_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= SKID_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // A flush drops both entries; a beat accepted in that cycle is simply not stored.
    always_comb begin
        state_d        = state_q;
        load_main_in   = 1'b0;
        load_main_skid = 1'b0;
        load_skid      = 1'b0;
        if (flush) begin
            state_d = SKID_EMPTY;
        end else begin
            case (state_q)
                SKID_EMPTY: begin
                    if (in_valid) begin
                        load_main_in = 1'b1;
                        state_d      = SKID_MAIN;
                    end
                end
                SKID_MAIN: begin
                    if (out_ready) begin
                        if (in_valid) begin
                            load_main_in = 1'b1;
                        end else begin
                            state_d = SKID_EMPTY;
                        end
                    end else if (in_valid) begin
                        load_skid = 1'b1;
                        state_d   = SKID_FULL;
                    end
                end
                SKID_FULL: begin
                    if (out_ready) begin
                        load_main_skid = 1'b1;
                        state_d        = SKID_MAIN;
                    end
                end
                default: begin
                    state_d = SKID_EMPTY;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            main_q <= '0;
            skid_q <= '0;
        end else begin
            if (load_main_in) begin
                main_q <= in_payload;
            end else if (load_main_skid) begin
                main_q <= skid_q;
            end
            if (load_skid) begin
                skid_q <= in_payload;
            end
        end
    end

endmodule

// File: rtl/pipe_stage_reg.sv
// Elastic pipeline stage register with flush, bubble gating and a saturating
// stall counter. Define PIPE_STAGE_SKID_EN to build in the registered-ready skid entry.
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int DATA_W   = XLEN,
    parameter int NUM_DATA = 2,
    parameter int CTRL_W   = 2,
    parameter int RD_W     = REG_IDX_W,
    parameter int CNT_W    = 16
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       flush,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [CTRL_W-1:0]          in_ctrl,
    input  logic [NUM_DATA*DATA_W-1:0] in_data,
    input  logic [RD_W-1:0]            in_rd,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [CTRL_W-1:0]          out_ctrl,
    output logic [NUM_DATA*DATA_W-1:0] out_data,
    output logic [RD_W-1:0]            out_rd,
    output logic [CNT_W-1:0]           stall_cnt
);

    localparam int               LANES_W = NUM_DATA * DATA_W;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic               held_valid;
    logic [CTRL_W-1:0]  held_ctrl;
    logic [LANES_W-1:0] held_data;
    logic [RD_W-1:0]    held_rd;
    logic [CNT_W-1:0]   stall_cnt_q;

`ifdef PIPE_STAGE_SKID_EN
    localparam int PAYLOAD_W = CTRL_W + LANES_W + RD_W;

    logic [PAYLOAD_W-1:0] held_payload;

    pipe_skid_buf #(
        .PAYLOAD_W (PAYLOAD_W)
    ) u_skid (
        .clk         (clk),
        .reset       (reset),
        .flush       (flush),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_payload  ({in_ctrl, in_data, in_rd}),
        .out_valid   (held_valid),
        .out_ready   (out_ready),
        .out_payload (held_payload)
    );

    assign {held_ctrl, held_data, held_rd} = held_payload;
`else
    assign in_ready = !held_valid || out_ready;

    // Payload only loads on accept, so bubbles and flushes leave data/rd untouched.
    always_ff @(posedge clk) begin
        if (reset) begin
            held_valid <= 1'b0;
            held_ctrl  <= '0;
            held_data  <= '0;
            held_rd    <= '0;
        end else if (flush) begin
            held_valid <= 1'b0;
        end else if (in_ready) begin
            held_valid <= in_valid;
            if (in_valid) begin
                held_ctrl <= in_ctrl;
                held_data <= in_data;
                held_rd   <= in_rd;
            end
        end
    end
`endif

    // Gate control so RegWrite/MemtoReg can never fire on a bubble.
    assign out_valid = held_valid;
    assign out_ctrl  = held_valid ? held_ctrl : '0;
    assign out_data  = held_data;
    assign out_rd    = held_rd;
    assign stall_cnt = stall_cnt_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt_q <= '0;
        end else if (held_valid && !out_ready && (stall_cnt_q != CNT_MAX)) begin
            stall_cnt_q <= stall_cnt_q + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench for pipe_stage_reg: reset, streaming, backpressure, flush,
// bubble and stall counter saturation, with hand-computed expectations.
module tb_pipe_stage_reg;
    import pipe_pkg::*;

    localparam int CNT_W = 4;
    localparam int DW    = 2 * XLEN;

    logic                 clk = 1'b0;
    logic                 reset;
    logic                 flush;
    logic                 in_valid;
    logic                 in_ready;
    logic [1:0]           in_ctrl;
    logic [DW-1:0]        in_data;
    logic [REG_IDX_W-1:0] in_rd;
    logic                 out_valid;
    logic                 out_ready;
    logic [1:0]           out_ctrl;
    logic [DW-1:0]        out_data;
    logic [REG_IDX_W-1:0] out_rd;
    logic [CNT_W-1:0]     stall_cnt;
    memwb_payload_t       beat;

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    assign in_ctrl = beat.ctrl;
    assign in_data = {beat.data1, beat.data0};
    assign in_rd   = beat.rd;

    pipe_stage_reg #(
        .DATA_W   (XLEN),
        .NUM_DATA (2),
        .CTRL_W   (2),
        .RD_W     (REG_IDX_W),
        .CNT_W    (CNT_W)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_ctrl   (in_ctrl),
        .in_data   (in_data),
        .in_rd     (in_rd),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_ctrl  (out_ctrl),
        .out_data  (out_data),
        .out_rd    (out_rd),
        .stall_cnt (stall_cnt)
    );

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_beat(input logic [1:0] c, input logic [4:0] r,
                            input logic [63:0] d0, input logic [63:0] d1);
        beat.ctrl  = c;
        beat.rd    = r;
        beat.data0 = d0;
        beat.data1 = d1;
    endtask

    initial begin
        // reset held two cycles with a live beat on the inputs
        reset     = 1'b1;
        flush     = 1'b0;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        set_beat(2'b11, 5'd0, 64'hDEAD, 64'h0);
        tick();
        tick();
        chk("reset_valid",    DW'(out_valid), DW'(0));
        chk("reset_ctrl",     DW'(out_ctrl),  DW'(0));
        chk("reset_data",     out_data,       DW'(0));
        chk("reset_rd",       DW'(out_rd),    DW'(0));
        chk("reset_stall",    DW'(stall_cnt), DW'(0));
        chk("reset_in_ready", DW'(in_ready),  DW'(1));
        reset    = 1'b0;
        in_valid = 1'b0;

        // streaming rd=1..8, one beat per cycle
        for (int i = 1; i <= 8; i++) begin
            in_valid = 1'b1;
            set_beat(2'b01, 5'(i), 64'(i), 64'(i * 16));
            tick();
            chk("stream_valid", DW'(out_valid), DW'(1));
            chk("stream_rd",    DW'(out_rd),    DW'(i));
        end
        in_valid = 1'b0;
        tick();
        chk("stream_drain", DW'(out_valid), DW'(0));

        // backpressure: rd=3 held for 5 stalled cycles, rd=4 waiting
        in_valid = 1'b1;
        set_beat(2'b11, 5'd3, 64'h0, 64'h1000);
        tick();
        chk("bp_load_rd", DW'(out_rd), DW'(3));
        out_ready = 1'b0;
        set_beat(2'b11, 5'd4, 64'h0, 64'h2000);
        #1;
`ifdef PIPE_STAGE_SKID_EN
        chk("bp_in_ready_first", DW'(in_ready), DW'(1));
`else
        chk("bp_in_ready_first", DW'(in_ready), DW'(0));
`endif
        for (int k = 1; k <= 5; k++) begin
            tick();
            chk("bp_valid", DW'(out_valid),      DW'(1));
            chk("bp_rd",    DW'(out_rd),         DW'(3));
            chk("bp_lane1", out_data[127:64],    DW'(64'h1000));
            chk("bp_ctrl",  DW'(out_ctrl),       DW'(2'b11));
            chk("bp_stall", DW'(stall_cnt),      DW'(k));
        end
        chk("bp_in_ready", DW'(in_ready), DW'(0));
        out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        chk("rel_valid", DW'(out_valid),   DW'(1));
        chk("rel_rd",    DW'(out_rd),      DW'(4));
        chk("rel_lane1", out_data[127:64], DW'(64'h2000));
        tick();
        chk("rel_drain", DW'(out_valid), DW'(0));
        chk("rel_stall", DW'(stall_cnt), DW'(5));

        // flush while a beat is held and a new beat is presented
        in_valid = 1'b1;
        set_beat(2'b01, 5'd10, 64'hAAAA, 64'h0);
        tick();
        chk("fl_hold_ctrl", DW'(out_ctrl), DW'(2'b01));
        out_ready = 1'b0;
        set_beat(2'b01, 5'd11, 64'hBBBB, 64'h0);
        flush = 1'b1;
        tick();
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        chk("fl_valid", DW'(out_valid),  DW'(0));
        chk("fl_ctrl",  DW'(out_ctrl),   DW'(0));
        chk("fl_rd",    DW'(out_rd),     DW'(10));
        chk("fl_lane0", out_data[63:0],  DW'(64'hAAAA));
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("fl_gone", DW'(out_valid), DW'(0));
        end

        // flush on an empty stage: the accepted beat is discarded
        in_valid = 1'b1;
        set_beat(2'b01, 5'd12, 64'hCCCC, 64'h0);
        flush = 1'b1;
        #1;
        chk("fl2_in_ready", DW'(in_ready), DW'(1));
        tick();
        flush    = 1'b0;
        in_valid = 1'b0;
        chk("fl2_valid", DW'(out_valid), DW'(0));
        chk("fl2_rd",    DW'(out_rd),    DW'(10));
        tick();
        chk("fl2_gone",  DW'(out_valid), DW'(0));
        chk("fl_stall",  DW'(stall_cnt), DW'(6));

        // one-cycle bubble between two ctrl=11 beats
        in_valid = 1'b1;
        set_beat(2'b11, 5'd20, 64'h20, 64'h0);
        tick();
        chk("bub_first_ctrl", DW'(out_ctrl), DW'(2'b11));
        chk("bub_first_rd",   DW'(out_rd),   DW'(20));
        in_valid = 1'b0;
        set_beat(2'b11, 5'd21, 64'h21, 64'h0);
        tick();
        chk("bub_valid",    DW'(out_valid),               DW'(0));
        chk("bub_ctrl",     DW'(out_ctrl),                DW'(0));
        chk("bub_regwrite", DW'(out_ctrl[CTRL_REGWRITE]), DW'(0));
        chk("bub_rd",       DW'(out_rd),                  DW'(20));
        chk("bub_lane0",    out_data[63:0],               DW'(64'h20));
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        chk("bub_second_rd",   DW'(out_rd),                  DW'(21));
        chk("bub_second_ctrl", DW'(out_ctrl),                DW'(2'b11));
        chk("bub_memtoreg",    DW'(out_ctrl[CTRL_MEMTOREG]), DW'(1));

        // stall counter saturation with CNT_W=4
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("sat_reset", DW'(stall_cnt), DW'(0));
        in_valid = 1'b1;
        set_beat(2'b01, 5'd7, 64'h7, 64'h0);
        tick();
        in_valid  = 1'b0;
        out_ready = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            tick();
            if (k == 14) chk("sat_14", DW'(stall_cnt), DW'(14));
            if (k == 15) chk("sat_15", DW'(stall_cnt), DW'(15));
        end
        chk("sat_hold",  DW'(stall_cnt), DW'(15));
        chk("sat_rd",    DW'(out_rd),    DW'(7));
        out_ready = 1'b1;
        tick();
        chk("sat_after", DW'(stall_cnt), DW'(15));
        chk("sat_drain", DW'(out_valid), DW'(0));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/pipe_stage_reg.md
# pipe_stage_reg

Parametrised elastic pipeline register for the RISC-V core, replacing the fixed per-stage latches (IF/ID through MEM/WB) with one block. It carries control bits, NUM_DATA data lanes and a destination register index. It adds valid/ready flow control, flush/bubble insertion and a saturating stall counter. An optional skid buffer removes the combinational ready path.

## Interface
Parameters:
- DATA_W, 64: width of one data lane (XLEN).
- NUM_DATA, 2: number of data lanes (e.g. read data and ALU/memory address for MEM/WB).
- CTRL_W, 2: control bit count (bit0 RegWrite, bit1 MemtoReg for MEM/WB).
- RD_W, 5: destination register index width.
- CNT_W, 16: stall counter width.

Ports:
- clk, input, 1: clock; all state updates on rising edge.
- reset, input, 1: reset, synchronous, active-high.
- flush, input, 1: kill every beat held in the stage.
- in_valid, input, 1: upstream beat present.
- in_ready, output, 1: stage accepts the beat this cycle.
- in_ctrl, input, CTRL_W: upstream control bits.
- in_data, input, NUM_DATA*DATA_W: lanes packed, lane 0 in the LSBs.
- in_rd, input, RD_W: destination register index.
- out_valid, output, 1: beat held for downstream.
- out_ready, input, 1: downstream accepts.
- out_ctrl, output, CTRL_W: control bits, forced 0 whenever out_valid=0.
- out_data, output, NUM_DATA*DATA_W: held data lanes.
- out_rd, output, RD_W: held destination index.
- stall_cnt, output, CNT_W: cycles with out_valid=1 and out_ready=0, saturating.

## Operation
- Accept condition: in_valid && in_ready.
- Output transfer condition: out_valid && out_ready.
- Reset: out_valid=0, out_ctrl=0, out_data=0, out_rd=0 and stall_cnt=0. With skid built in, the skid entry is also invalid and in_ready=1 in the first cycle after reset.
- Base mode (no skid):
  - in_ready = !out_valid || out_ready, which is combinational.
  - When in_ready=1, the main register loads in_valid. On accept it also loads ctrl, data and rd.
  - When in_ready=1 and in_valid=0, the stage takes a bubble: out_valid=0 and out_ctrl=0, while data and rd hold their previous value.
- Flush:
  - Next cycle out_valid=0 and out_ctrl=0, and any skid entry is invalidated. Data and rd hold.
  - A beat accepted in the flush cycle is consumed and discarded.
  - Flush has priority over accept and over reset-free transfer. Reset has priority over flush.
- Bubble gating: out_ctrl is zero whenever out_valid=0, so RegWrite never fires on a bubble.
- stall_cnt:
  - Increments each cycle with out_valid && !out_ready.
  - Saturates at 2^CNT_W-1, with no wrap.
  - Cleared only by reset; flush does not clear it.
- No beat is duplicated or reordered. Data is delivered strictly in FIFO order.

## Timing
- Latency: 1 cycle from accept to out_valid.
- Throughput: 1 beat per cycle while out_ready=1.
- Base mode: in_ready depends combinationally on out_ready.
- Skid mode: in_ready is a flop output and does not depend combinationally on out_ready.
- Back-to-back accepts with out_ready held at 1 give a continuous out_valid.
- The outputs of a held beat are stable while out_valid=1 and out_ready=0.

## Configuration
- PIPE_STAGE_SKID_EN defined:
  - A second (skid) entry is added and in_ready = !skid_valid, registered.
  - A beat accepted while the main entry is stalled goes to the skid entry.
  - On transfer, the skid entry moves into the main entry in the same edge and in_ready rises the following cycle.
  - Capacity is 2 beats.
- PIPE_STAGE_SKID_EN undefined: base mode, capacity 1 beat, combinational in_ready.

## Structure
- Shared package pipe_pkg holds:
  - XLEN=64 and REG_IDX_W=5.
  - Control bit index constants CTRL_REGWRITE=0 and CTRL_MEMTOREG=1.
  - A per-stage typedef for the MEM/WB payload (ctrl, two lanes, rd).
- One sub-module is natural: pipe_skid_buf, the 2-entry main+skid store with its valid flags. It is instantiated only under PIPE_STAGE_SKID_EN. The top level keeps flush, bubble gating and stall_cnt.

## Test plan
- Reset:
  - Stimulus: hold reset 2 cycles with in_valid=1, in_ctrl=2'b11, in_data lane0=64'hDEAD.
  - Required: out_valid=0, out_ctrl=0, out_data=0, stall_cnt=0 and in_ready=1.
- Streaming:
  - Stimulus: beats rd=1..8 on consecutive cycles with out_ready=1.
  - Required: out_rd=1..8 on 8 consecutive cycles, each 1 cycle after its input, with no gaps.
- Backpressure:
  - Stimulus: out_ready=0 for 5 cycles with a beat held (rd=3, lane1=64'h1000).
  - Required: outputs are stable and stall_cnt=5. In base mode in_ready=0. In skid mode one extra beat (rd=4) is accepted and then in_ready=0. After release, rd=3 is followed by rd=4.
- Flush:
  - Stimulus: flush asserted while a beat with ctrl=2'b01 is held and a new beat is presented.
  - Required: next cycle out_valid=0 and out_ctrl=0, and neither beat ever appears at the output.
- Bubble:
  - Stimulus: in_valid=0 for 1 cycle between two beats with ctrl=2'b11.
  - Required: one cycle with out_valid=0 and out_ctrl=2'b00, and data unchanged.
- Saturation:
  - Stimulus: CNT_W=4, 20 stall cycles.
  - Required: stall_cnt=15, held, and no wrap.
